gc_responder: RTL and testbench

Fabric-side GameCube controller emulator: the device end of the single-wire controller protocol that the `gc` host block drives on `controller_data`. It decodes host commands sampled from the open-drain line and answers identify and poll commands with encoded reply frames. The poll reply carries a 64-bit button/stick word supplied by the fabric. It is used as a loopback target for bench and bring-up testing of the host reader, wired onto the same bus net.

---
 rtl/gc_responder.sv | 175 +++++++++++++++++
 tb/tb_gc_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_responder.sv
// GameCube controller device-side emulator: decodes host commands off the open-drain
// bus and answers identify/poll with encoded reply frames driven through data_oe.
module gc_responder #(
    parameter int TICKS_PER_US = 10,
    parameter int TIMEOUT_US   = 5,
    parameter int TURN_US      = 4
) (
    input  logic        SYSCLK,
    input  logic        SYSRESET,
    input  logic        data_in,
    output logic        data_oe,
    input  logic [63:0] button_state,
    output logic [23:0] cmd,
    output logic        cmd_valid,
    output logic        rumble,
    output logic        busy
);

    localparam logic [15:0] TO_TICKS   = 16'(TIMEOUT_US * TICKS_PER_US);
    localparam logic [15:0] TURN_TICKS = 16'(TURN_US * TICKS_PER_US);
    localparam logic [15:0] BIT_TICKS  = 16'(4 * TICKS_PER_US);
    localparam logic [15:0] ONE_LOW    = 16'(TICKS_PER_US);
    localparam logic [15:0] ZERO_LOW   = 16'(3 * TICKS_PER_US);
    localparam logic [15:0] STOP_TICKS = 16'(2 * TICKS_PER_US);
    localparam logic [15:0] ONE_MAX    = 16'(2 * TICKS_PER_US);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_LOW  = 3'd1;
    localparam logic [2:0] S_RX_HIGH = 3'd2;
    localparam logic [2:0] S_DECODE  = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;
    localparam logic [2:0] S_TX_BIT  = 3'd5;
    localparam logic [2:0] S_TX_STOP = 3'd6;

    logic [2:0]  state;
    logic        sync1, sync2, sync_d;
    logic        fall, rise;
    logic [15:0] lo_cnt, hi_cnt, tmr;
    logic [24:0] rx_sr;
    logic [4:0]  bit_cnt;
    logic [63:0] tx_sr;
    logic [6:0]  tx_left;
    logic [15:0] tmr_nxt;
    logic [15:0] low_len;

    // sync flops idle high so the pulled-up bus never fakes an edge out of reset
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= data_in;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign fall    = sync_d & ~sync2;
    assign rise    = ~sync_d & sync2;
    assign busy    = (state != S_IDLE);
    assign tmr_nxt = tmr + 16'd1;
    assign low_len = tx_sr[63] ? ONE_LOW : ZERO_LOW;

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state     <= S_IDLE;
            data_oe   <= 1'b0;
            cmd       <= 24'h0;
            cmd_valid <= 1'b0;
            rumble    <= 1'b0;
            lo_cnt    <= 16'h0;
            hi_cnt    <= 16'h0;
            tmr       <= 16'h0;
            rx_sr     <= 25'h0;
            bit_cnt   <= 5'h0;
            tx_sr     <= 64'h0;
            tx_left   <= 7'h0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    data_oe <= 1'b0;
                    if (fall) begin
                        state   <= S_RX_LOW;
                        lo_cnt  <= 16'd1;
                        bit_cnt <= 5'd0;
                    end
                end
                S_RX_LOW: begin
                    if (rise) begin
                        rx_sr   <= {rx_sr[23:0], (lo_cnt < ONE_MAX)};
                        bit_cnt <= (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;
                        hi_cnt  <= 16'd1;
                        state   <= S_RX_HIGH;
                    end else if (lo_cnt >= TO_TICKS) begin
                        // low held too long: treat as a bus fault, drop the frame
                        state <= S_IDLE;
                    end else if (lo_cnt != CNT_MAX) begin
                        lo_cnt <= lo_cnt + 16'd1;
                    end
                end
                S_RX_HIGH: begin
                    if (fall) begin
                        lo_cnt <= 16'd1;
                        state  <= S_RX_LOW;
                    end else if (hi_cnt >= TO_TICKS) begin
                        state <= S_DECODE;
                    end else if (hi_cnt != CNT_MAX) begin
                        hi_cnt <= hi_cnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    // rx_sr[0] holds the host stop bit and is never part of the command
                    tmr <= 16'd0;
                    if (bit_cnt == 5'd9 && rx_sr[8:1] == 8'h00) begin
                        cmd       <= 24'h000000;
                        cmd_valid <= 1'b1;
                        tx_sr     <= {24'h090003, 40'h0};
                        tx_left   <= 7'd24;
                        state     <= S_TURN;
                    end else if (bit_cnt == 5'd25 && rx_sr[24:17] == 8'h40) begin
                        cmd       <= rx_sr[24:1];
                        rumble    <= rx_sr[1];
                        cmd_valid <= 1'b1;
                        tx_sr     <= button_state;
                        tx_left   <= 7'd64;
                        state     <= S_TURN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TURN: begin
                    if (tmr == TURN_TICKS - 16'd1) begin
                        tmr     <= 16'd0;
                        data_oe <= 1'b1;
                        state   <= S_TX_BIT;
                    end else begin
                        tmr <= tmr_nxt;
                    end
                end
                S_TX_BIT: begin
                    if (tmr == BIT_TICKS - 16'd1) begin
                        tmr     <= 16'd0;
                        data_oe <= 1'b1;
                        if (tx_left == 7'd1) begin
                            state <= S_TX_STOP;
                        end else begin
                            tx_sr   <= {tx_sr[62:0], 1'b0};
                            tx_left <= tx_left - 7'd1;
                        end
                    end else begin
                        tmr     <= tmr_nxt;
                        data_oe <= (tmr_nxt < low_len);
                    end
                end
                S_TX_STOP: begin
                    if (tmr == STOP_TICKS - 16'd1) begin
                        tmr     <= 16'd0;
                        data_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        tmr <= tmr_nxt;
                    end
                end
                default: begin
                    data_oe <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gc_responder.sv
// Bench for gc_responder: drives host command waveforms on data_in and scoreboards
// cmd_valid/cmd and the decoded reply frames seen on data_oe.
module tb_gc_responder;

    typedef struct {
        logic [63:0] data;
        int          len;
    } reply_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_in;
    logic        data_oe;
    logic [63:0] button_state;
    logic [23:0] cmd;
    logic        cmd_valid;
    logic        rumble;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [23:0] cmd_q[$];
    reply_t      rep_q[$];

    always #50 clk = ~clk;

    gc_responder #(.TICKS_PER_US(10), .TIMEOUT_US(5), .TURN_US(4)) dut (
        .SYSCLK(clk), .SYSRESET(rst), .data_in(data_in), .data_oe(data_oe),
        .button_state(button_state), .cmd(cmd), .cmd_valid(cmd_valid),
        .rumble(rumble), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // cmd_valid scoreboard
    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            if (cmd_q.size() == 0) chk("cv_unexpected", 64'd1, 64'd0);
            else chk("cmd", 64'(cmd), 64'(cmd_q.pop_front()));
        end
    end

    // reply decoder: classify each low pulse by its length
    int          run = 0, nb = 0, flen = 0;
    logic        in_frame = 1'b0;
    logic [63:0] bits = 64'h0;
    always @(negedge clk) begin
        if (rst) begin
            run = 0; nb = 0; flen = 0; in_frame = 1'b0; bits = 64'h0;
        end else begin
            if (in_frame) flen++;
            if (data_oe) begin
                if (!in_frame) begin
                    in_frame = 1'b1; flen = 1; nb = 0; bits = 64'h0;
                end
                run++;
            end else if (run > 0) begin
                if (run == 10) begin
                    bits = {bits[62:0], 1'b1}; nb++;
                end else if (run == 30) begin
                    bits = {bits[62:0], 1'b0}; nb++;
                end else if (run == 20) begin
                    if (rep_q.size() == 0) chk("reply_unexpected", 64'd1, 64'd0);
                    else begin
                        reply_t e;
                        e = rep_q.pop_front();
                        chk("reply_data", bits, e.data);
                        chk("reply_bits", 64'(nb), 64'(e.len));
                        chk("frame_len", 64'(flen - 1), 64'(e.len * 40 + 20));
                    end
                    in_frame = 1'b0;
                end else begin
                    chk("low_len", 64'(run), 64'd10);
                end
                run = 0;
            end
        end
    end

    task automatic drive(input logic v, input int cyc);
        data_in = v;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // host frame MSB first, then a 1us-low stop bit; returns right after release
    task automatic host_send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b0, v[i] ? 10 : 30);
            drive(1'b1, v[i] ? 30 : 10);
        end
        drive(1'b0, 10);
        data_in = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // accepted command: check latencies, optionally wait for the frame to finish
    task automatic valid_cmd(input logic [31:0] v, input int n, input logic finish);
        int cnt;
        host_send(v, n);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (cmd_valid) break;
        end
        chk("cv_latency", 64'(cnt), 64'd54);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (data_oe) break;
        end
        chk("turn_latency", 64'(cnt), 64'd40);
        if (finish) wait_idle();
    endtask

    // rejected stimulus: bus must stay released and no pulse appear
    task automatic quiet_window(input string tag);
        logic oe_seen, cv_seen;
        oe_seen = 1'b0; cv_seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            oe_seen |= data_oe;
            cv_seen |= cmd_valid;
        end
        chk({tag, "_oe"}, 64'(oe_seen), 64'd0);
        chk({tag, "_cv"}, 64'(cv_seen), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic push_poll(input logic [23:0] c);
        reply_t r;
        cmd_q.push_back(c);
        r.data = button_state; r.len = 64;
        rep_q.push_back(r);
    endtask

    task automatic push_ident();
        reply_t r;
        cmd_q.push_back(24'h000000);
        r.data = 64'h090003; r.len = 24;
        rep_q.push_back(r);
    endtask

    initial begin
        rst = 1'b1; data_in = 1'b1; button_state = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe", 64'(data_oe), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        chk("rst_cv", 64'(cmd_valid), 64'd0);
        chk("rst_rumble", 64'(rumble), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        push_ident();
        valid_cmd(32'h00, 8, 1'b1);

        button_state = 64'h0123456789ABCDEF;
        push_poll(24'h400300);
        valid_cmd(32'h400300, 24, 1'b1);
        chk("rumble_off", 64'(rumble), 64'd0);

        button_state = 64'hFEDCBA9876543210;
        push_poll(24'h400301);
        valid_cmd(32'h400301, 24, 1'b1);
        chk("rumble_on", 64'(rumble), 64'd1);
        push_poll(24'h400300);
        valid_cmd(32'h400300, 24, 1'b1);
        chk("rumble_clr", 64'(rumble), 64'd0);

        host_send(32'h41, 8);
        quiet_window("bad_ident");
        host_send(32'hABC, 12);
        quiet_window("bad_len");
        host_send(32'h4003001, 28);
        quiet_window("too_long");

        // low held past the timeout aborts the frame
        drive(1'b0, 60);
        data_in = 1'b1;
        quiet_window("long_low");

        // frame must not follow button_state once the reply has started
        button_state = 64'hA5A5_5A5A_C3C3_3C3C;
        push_poll(24'h400300);
        valid_cmd(32'h400300, 24, 1'b0);
        repeat (200) @(posedge clk);
        #1;
        button_state = 64'h0;
        wait_idle();

        button_state = 64'h1111_2222_3333_4444;
        cmd_q.push_back(24'h400300);
        valid_cmd(32'h400300, 24, 1'b0);
        repeat (300) @(posedge clk);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (data_oe) break;
            end
        end
        chk("pre_rst_oe", 64'(data_oe), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_oe", 64'(data_oe), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        push_ident();
        valid_cmd(32'h00, 8, 1'b1);

        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("rep_q_empty", 64'(rep_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
